dut_vector_engine: RTL and testbench

//   Single-clock, parametrised DUT stimulus/response engine for the chip tester.

---
 rtl/dut_vector_engine.sv | 125 ++++++++++++
 tb/tb_dut_vector_engine.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_vector_engine.sv
// dut_vector_engine
// Drives one stimulus vector onto the DUT pins, waits a programmable settle
// time, samples the DUT response and returns it with a masked pass/fail flag.
// Keeps saturating counts of completed and failed vectors.
module dut_vector_engine #(
    parameter int STF_WIDTH   = 24,
    parameter int RTF_WIDTH   = 24,
    parameter int CYCLE_RANGE = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   mode,
    input  logic                   stim_valid,
    output logic                   stim_ready,
    input  logic [STF_WIDTH-1:0]   stim_data,
    input  logic [CYCLE_RANGE-1:0] stim_cycles,
    input  logic [RTF_WIDTH-1:0]   stim_expect,
    input  logic [RTF_WIDTH-1:0]   stim_mask,
    output logic [STF_WIDTH-1:0]   mosi,
    input  logic [RTF_WIDTH-1:0]   miso,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [RTF_WIDTH-1:0]   res_data,
    output logic                   res_fail,
    output logic                   busy,
    input  logic                   clear_counts,
    output logic [CNT_WIDTH-1:0]   vec_count,
    output logic [CNT_WIDTH-1:0]   fail_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [CYCLE_RANGE-1:0] cnt_reg;
    logic [RTF_WIDTH-1:0]   expect_reg;
    logic [RTF_WIDTH-1:0]   mask_reg;
    logic                   mode_reg;
    logic [RTF_WIDTH-1:0]   miss_bits;
    logic                   accept;
    logic                   retire;

    // Acceptance depends only on the state register and the enable/reset pins.
    assign stim_ready = (state_reg == IDLE) & enable & ~reset;
    assign accept     = stim_valid & stim_ready;
    assign retire     = (state_reg == EMIT) & res_ready;
    assign busy       = (state_reg != IDLE);

    // Per-bit masked mismatch between the live response and the latched expectation.
    generate
        for (genvar gi = 0; gi < RTF_WIDTH; gi++) begin : g_miss
            assign miss_bits[gi] = (miso[gi] ^ expect_reg[gi]) & mask_reg[gi];
        end
    endgenerate

    // Vector sequencer: accept, settle countdown, sample, hold result until consumed.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            expect_reg <= '0;
            mask_reg   <= '0;
            mode_reg   <= 1'b0;
            mosi       <= '0;
            res_data   <= '0;
            res_valid  <= 1'b0;
            res_fail   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        expect_reg <= stim_expect;
                        mask_reg   <= stim_mask;
                        mode_reg   <= mode;
                        cnt_reg    <= stim_cycles;
                        mosi       <= stim_data;
                        state_reg  <= APPLY;
                    end
                end
                APPLY: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        res_data  <= miso;
                        res_fail  <= mode_reg & (|miss_bits);
                        res_valid <= 1'b1;
                        state_reg <= EMIT;
                    end
                end
                EMIT: begin
                    // res_data/res_fail stay put until the consumer takes them.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Completed-vector counter: clear beats increment, saturates at all-ones.
    always_ff @(posedge clock) begin
        if (reset || clear_counts) begin
            vec_count <= '0;
        end else if (retire && !(&vec_count)) begin
            vec_count <= vec_count + 1'b1;
        end
    end

    // Failed-vector counter: same clear/saturation rules, counts only flagged results.
    always_ff @(posedge clock) begin
        if (reset || clear_counts) begin
            fail_count <= '0;
        end else if (retire && res_fail && !(&fail_count)) begin
            fail_count <= fail_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dut_vector_engine.sv
// Testbench for dut_vector_engine: directed scenarios plus randomized vectors,
// with a scoreboard queue filled at accept time and drained by a result monitor.
module tb_dut_vector_engine;

    localparam int SW = 24;
    localparam int RW = 24;
    localparam int CR = 5;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          mode = 1'b0;
    logic          stim_valid = 1'b0;
    logic          stim_ready;
    logic [SW-1:0] stim_data = '0;
    logic [CR-1:0] stim_cycles = '0;
    logic [RW-1:0] stim_expect = '0;
    logic [RW-1:0] stim_mask = '0;
    logic [SW-1:0] mosi;
    logic [RW-1:0] miso;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_data;
    logic          res_fail;
    logic          busy;
    logic          clear_counts = 1'b0;
    logic [CW-1:0] vec_count;
    logic [CW-1:0] fail_count;

    dut_vector_engine #(
        .STF_WIDTH  (SW),
        .RTF_WIDTH  (RW),
        .CYCLE_RANGE(CR),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .stim_valid  (stim_valid),
        .stim_ready  (stim_ready),
        .stim_data   (stim_data),
        .stim_cycles (stim_cycles),
        .stim_expect (stim_expect),
        .stim_mask   (stim_mask),
        .mosi        (mosi),
        .miso        (miso),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_fail    (res_fail),
        .busy        (busy),
        .clear_counts(clear_counts),
        .vec_count   (vec_count),
        .fail_count  (fail_count)
    );

    always #5 clock = ~clock;

    // Edge index: the value seen at a rising edge is that edge's number.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // DUT pin model: response is a per-edge pattern unless a fixed value is forced.
    logic          miso_force_en = 1'b0;
    logic [RW-1:0] miso_force = '0;

    function automatic logic [RW-1:0] pat(input int c);
        logic [31:0] x;
        x = c * 32'h9E3779B1;
        x = x ^ (x >> 13);
        return x[RW-1:0];
    endfunction

    assign miso = miso_force_en ? miso_force : pat(cyc);

    typedef struct {
        logic [RW-1:0] data;
        logic          fail;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   model_vec = 0;
    int   model_fail = 0;
    localparam int CNT_MAX = (1 << CW) - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // res_ready driver: random backpressure or a fixed level chosen by the stimulus.
    logic rr_rand = 1'b0;
    logic rr_val  = 1'b0;
    initial begin
        forever begin
            @(posedge clock);
            #2;
            res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
        end
    end

    // Monitor: check counters every cycle, pop and compare on each result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            chk("vec_count", 32'(vec_count), 32'(model_vec));
            chk("fail_count", 32'(fail_count), 32'(model_fail));
            if (reset || clear_counts) begin
                model_vec  = 0;
                model_fail = 0;
            end
            if (!reset && res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 32'(res_valid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("res_data", 32'(res_data), 32'(e.data));
                    chk("res_fail", 32'(res_fail), 32'(e.fail));
                    if (!clear_counts) begin
                        if (model_vec < CNT_MAX) model_vec++;
                        if (e.fail && model_fail < CNT_MAX) model_fail++;
                    end
                end
                $display("result: data=%06h fail=%0d vec=%0d", res_data, res_fail, vec_count);
            end
        end
    end

    // Offer one vector, wait for acceptance, queue the expected result.
    task automatic send(input logic m, input logic [SW-1:0] d, input logic [CR-1:0] c,
                        input logic [RW-1:0] ex, input logic [RW-1:0] mk, output int t);
        int   n;
        exp_t e;
        @(posedge clock);
        #1;
        mode        = m;
        stim_data   = d;
        stim_cycles = c;
        stim_expect = ex;
        stim_mask   = mk;
        stim_valid  = 1'b1;
        n = 0;
        @(negedge clock);
        while (!stim_ready && n < 300) begin
            n++;
            @(negedge clock);
        end
        if (!stim_ready) begin
            chk("accept_timeout", 32'(stim_ready), 32'd1);
            stim_valid = 1'b0;
            t = -1;
            return;
        end
        t = cyc;
        e.data = miso_force_en ? miso_force : pat(t + int'(c) + 1);
        e.fail = m & (|((e.data ^ ex) & mk));
        sbq.push_back(e);
        $display("send: mode=%0d data=%06h cycles=%0d expect=%06h mask=%06h edge=%0d",
                 m, d, c, ex, mk, t);
        @(posedge clock);
        #1;
        stim_valid  = 1'b0;
        stim_data   = SW'($urandom);
        stim_expect = RW'($urandom);
        chk("mosi_after_accept", 32'(mosi), 32'(d));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while ((busy || sbq.size() != 0) && n < 500) begin
            n++;
            @(negedge clock);
        end
        chk("idle_timeout", 32'(busy || sbq.size() != 0), 32'd0);
    endtask

    task automatic pulse_clear();
        @(posedge clock);
        #1 clear_counts = 1'b1;
        @(posedge clock);
        #1 clear_counts = 1'b0;
    endtask

    // Overall time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            t;
        int            n;
        logic [RW-1:0] held;
        logic [SW-1:0] d;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_mosi", 32'(mosi), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_res_data", 32'(res_data), 32'd0);
        chk("reset_stim_ready", 32'(stim_ready), 32'd1);

        // Capture mode, single settle cycle.
        rr_val = 1'b0;
        miso_force_en = 1'b1;
        miso_force = 24'h123456;
        send(1'b0, 24'hA5A5A5, 5'd0, 24'h0, 24'h0, t);
        @(negedge clock);
        chk("t1_valid_early", 32'(res_valid), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clock);
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_data", 32'(res_data), 32'h123456);
        chk("t1_fail", 32'(res_fail), 32'd0);
        @(posedge clock);
        #1 rr_val = 1'b1;
        wait_idle();

        // Compare mode through a mask.
        pulse_clear();
        miso_force = 24'h000F0F;
        send(1'b1, 24'h000001, 5'd0, 24'h0000FF, 24'h00000F, t);
        wait_idle();
        miso_force = 24'h00000E;
        send(1'b1, 24'h000002, 5'd0, 24'h0000FF, 24'h00000F, t);
        wait_idle();
        chk("t2_fail_count", 32'(fail_count), 32'd1);
        chk("t2_vec_count", 32'(vec_count), 32'd2);
        miso_force_en = 1'b0;

        // Longest settle with held-off consumer.
        @(posedge clock);
        #1 rr_val = 1'b0;
        d = 24'h3C3C3C;
        send(1'b0, d, 5'd31, 24'h0, 24'h0, t);
        n = 0;
        @(negedge clock);
        while (!res_valid && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("t3_latency", 32'(n), 32'd32);
        held = res_data;
        stim_valid = 1'b1;
        repeat (10) begin
            @(negedge clock);
            chk("t3_hold_data", 32'(res_data), 32'(held));
            chk("t3_hold_valid", 32'(res_valid), 32'd1);
            chk("t3_stim_ready", 32'(stim_ready), 32'd0);
            chk("t3_mosi_hold", 32'(mosi), 32'(d));
        end
        @(posedge clock);
        #1 stim_valid = 1'b0;
        rr_val = 1'b1;
        wait_idle();
        chk("t3_mosi_after", 32'(mosi), 32'(d));

        // Counter saturation, then clear coincident with an increment.
        pulse_clear();
        repeat (17) send(1'b0, SW'($urandom), 5'd0, 24'h0, 24'h0, t);
        wait_idle();
        chk("t4_saturate", 32'(vec_count), 32'hF);
        @(posedge clock);
        #1 rr_val = 1'b0;
        send(1'b0, SW'($urandom), 5'd0, 24'h0, 24'h0, t);
        n = 0;
        @(negedge clock);
        while (!res_valid && n < 50) begin
            n++;
            @(negedge clock);
        end
        chk("t4_valid", 32'(res_valid), 32'd1);
        @(posedge clock);
        #1 rr_val = 1'b1;
        clear_counts = 1'b1;
        @(posedge clock);
        #1 clear_counts = 1'b0;
        @(negedge clock);
        chk("t4_clear_wins", 32'(vec_count), 32'd0);
        wait_idle();

        // Reset in the middle of a long settle.
        send(1'b0, 24'h5A5A5A, 5'd10, 24'h0, 24'h0, t);
        @(posedge clock);
        #1 reset = 1'b1;
        void'(sbq.pop_back());
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("t5_mosi", 32'(mosi), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_res_valid", 32'(res_valid), 32'd0);
        chk("t5_vec_count", 32'(vec_count), 32'd0);
        repeat (15) @(negedge clock);
        chk("t5_no_result", 32'(sbq.size()), 32'd0);

        // Enable gating of acceptance.
        @(posedge clock);
        #1 enable = 1'b0;
        stim_valid = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("t6_ready_low", 32'(stim_ready), 32'd0);
            chk("t6_no_accept", 32'(busy), 32'd0);
        end
        @(posedge clock);
        #1 stim_valid = 1'b0;
        enable = 1'b1;
        send(1'b0, 24'h777777, 5'd6, 24'h0, 24'h0, t);
        #1 enable = 1'b0;
        wait_idle();
        chk("t6_completed_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1 enable = 1'b1;

        // Randomized vectors with random backpressure and occasional clears.
        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [RW-1:0] mk;
            mk = ($urandom_range(0, 3) == 0) ? RW'(0) : (RW'(1) << $urandom_range(0, RW - 1));
            send(1'($urandom_range(0, 1)), SW'($urandom), CR'($urandom_range(0, 7)),
                 RW'($urandom), mk, t);
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clock);
                #1 clear_counts = 1'b1;
                @(posedge clock);
                #1 clear_counts = 1'b0;
            end
        end
        wait_idle();
        rr_rand = 1'b0;
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
